// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a byte FIFO and a TX-done interrupt.
module uart_tx_port #(
  parameter int CLK_DIV   = 104,
  parameter int FIFO_BITS = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sel,
  input  logic        addr0,
  input  logic        mem_valid,
  input  logic        mem_nwr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        interrupt,
  input  logic        interrupt_clear,
  output logic        tx
);
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic tx_q, ready_q, ovf_q, irq_q;
  logic [31:0] dout_q;
  logic [7:0] fifo_q [DEPTH];
  logic [FIFO_BITS:0] wr_q, rd_q, count;
  logic req, act, wr_data, rd_stat, empty, full, tick, pop, push, done, ovf_set;
  logic [31:0] status;
  logic unused;
  assign unused = ^mem_data_in[31:8];
  assign req = mem_valid & sel;
  assign act = req & ~ready_q;
  assign wr_data = act & ~mem_nwr & ~addr0;
  assign rd_stat = act & mem_nwr & addr0;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[FIFO_BITS] != rd_q[FIFO_BITS]) && (wr_q[FIFO_BITS-1:0] == rd_q[FIFO_BITS-1:0]);
  assign count = wr_q - rd_q;
  assign tick = cnt_q == '0;
  assign pop = ~empty & ((state_q == IDLE) | (state_q == STOP & tick));
  assign done = (state_q == STOP) & tick & empty;
  // a pop in the same cycle frees a slot, so a write to a full FIFO still lands
  assign push = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;
  assign status = 32'({count, ovf_q, state_q != IDLE, empty, full});
  assign mem_data_out = dout_q;
  assign mem_ready = ready_q;
  assign interrupt = irq_q;
  assign tx = tx_q;
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q[FIFO_BITS-1:0]] <= mem_data_in[7:0];
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
      ready_q <= 1'b0;
      dout_q <= '0;
    end else begin
      ready_q <= req;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      ovf_q <= ovf_set | (ovf_q & ~rd_stat);
      irq_q <= done | (irq_q & ~(interrupt_clear | wr_data));
      if (act & mem_nwr) dout_q <= addr0 ? status : '0;
    end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          cnt_q <= RELOAD;
          shift_q <= fifo_q[rd_q[FIFO_BITS-1:0]];
          tx_q <= 1'b0;
        end
        START: if (tick) begin
          state_q <= DATA;
          cnt_q <= RELOAD;
          idx_q <= '0;
          tx_q <= shift_q[0];
        end else cnt_q <= cnt_q - 1'b1;
        DATA: if (tick) begin
          cnt_q <= RELOAD;
          if (idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 3'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            tx_q <= shift_q[1];
          end
        end else cnt_q <= cnt_q - 1'b1;
        STOP: if (tick) begin
          if (pop) begin
            state_q <= START;
            cnt_q <= RELOAD;
            shift_q <= fifo_q[rd_q[FIFO_BITS-1:0]];
            tx_q <= 1'b0;
          end else state_q <= IDLE;
        end else cnt_q <= cnt_q - 1'b1;
      endcase
    end
endmodule
